// File: rtl/game_input_pkg.sv
// Shared button indices, move encodings and shoot FSM states for the
// two-player input front end.
package game_input_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SHOOT = 4;

    localparam logic [3:0] MOVE_NONE  = 4'b0000;
    localparam logic [3:0] MOVE_UP    = 4'b0001;
    localparam logic [3:0] MOVE_DOWN  = 4'b0010;
    localparam logic [3:0] MOVE_LEFT  = 4'b0100;
    localparam logic [3:0] MOVE_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        FIRE     = 2'd2,
        COOLDOWN = 2'd3
    } shoot_state_t;

    // Lowest set bit wins; bit 0 is "up", so this is the up>down>left>right priority.
    function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_o <= 1'b0;
            if (sync_q[1] == level_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // rise_o coincides with the first cycle of the new level
                level_o <= sync_q[1];
                rise_o  <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/player_input_ctrl.sv
// Two-player button front end: debounced buttons become per-frame move
// commands (last-pressed wins) and single-frame shoot pulses with cooldown.
module player_input_ctrl
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_tick_i,
    input  logic [4:0] p1_btn_i,
    input  logic [4:0] p2_btn_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic [3:0] dbg_shoot_state_o
);

    logic [1:0][4:0] btn_raw;
    logic [1:0][4:0] btn_level;
    logic [1:0][4:0] btn_rise;
    logic [1:0][3:0] move_all;
    logic [1:0]      shoot_all;
    logic [1:0][1:0] state_all;

    assign btn_raw = {p2_btn_i, p1_btn_i};

    for (genvar p = 0; p < 2; p++) begin : g_btn_p
        for (genvar b = 0; b < 5; b++) begin : g_btn_b
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk_i   (clk_i),
                .reset_ni(reset_ni),
                .btn_i   (btn_raw[p][b]),
                .level_o (btn_level[p][b]),
                .rise_o  (btn_rise[p][b])
            );
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [3:0]   held;
        logic [3:0]   last_q;
        logic [3:0]   last_eff;
        logic [3:0]   dir_next;
        logic [3:0]   move_q;
        shoot_state_t state_q;
        shoot_state_t state_d;
        logic [7:0]   cd_q;
        logic [7:0]   cd_d;

        always_comb begin
            held     = btn_level[p][3:0];
            // A press in this very cycle already counts as the last-pressed one
            last_eff = (|btn_rise[p][3:0]) ? lowest_onehot(btn_rise[p][3:0]) : last_q;
            if (|(last_eff & held)) begin
                dir_next = last_eff;
            end else begin
                dir_next = lowest_onehot(held);
            end
        end

        always_comb begin
            state_d = state_q;
            cd_d    = cd_q;
            case (state_q)
                IDLE: begin
                    if (btn_rise[p][BTN_SHOOT]) state_d = ARMED;
                end
                ARMED: begin
                    if (frame_tick_i) state_d = FIRE;
                end
                FIRE: begin
                    if (frame_tick_i) begin
                        state_d = COOLDOWN;
                        cd_d    = 8'(COOLDOWN_FRAMES);
                    end
                end
                COOLDOWN: begin
                    if (frame_tick_i) begin
                        if (cd_q <= 8'd1) begin
                            state_d = IDLE;
                            cd_d    = 8'd0;
                        end else begin
                            cd_d = cd_q - 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                last_q  <= MOVE_NONE;
                move_q  <= MOVE_NONE;
                state_q <= IDLE;
                cd_q    <= 8'd0;
            end else begin
                last_q  <= last_eff;
                state_q <= state_d;
                cd_q    <= cd_d;
                if (frame_tick_i) move_q <= dir_next;
            end
        end

        assign move_all[p]  = move_q;
        assign shoot_all[p] = (state_q == FIRE);
        assign state_all[p] = state_q;
    end

    assign player_1_move_o   = move_all[0];
    assign player_2_move_o   = move_all[1];
    assign player_1_shoot_o  = shoot_all[0];
    assign player_2_shoot_o  = shoot_all[1];
    assign dbg_shoot_state_o = state_all;

endmodule
